// File: rtl/wb_pkg.sv
// Shared writeback-arbiter definitions: mux select codes, source indices and helpers.
// Build option: define WB_ARB_RR_EN for round-robin grant instead of fixed priority.
package wb_pkg;

  localparam logic [1:0] WB_SEL_ALU  = 2'b00;
  localparam logic [1:0] WB_SEL_LOAD = 2'b01;
  localparam logic [1:0] WB_SEL_LINK = 2'b10;

  typedef enum logic [1:0] {
    SRC_ALU  = 2'd0,
    SRC_LOAD = 2'd1,
    SRC_LINK = 2'd2
  } wb_src_e;

  function automatic logic [1:0] src_to_sel(input wb_src_e src);
    case (src)
      SRC_LOAD: return WB_SEL_LOAD;
      SRC_LINK: return WB_SEL_LINK;
      default:  return WB_SEL_ALU;
    endcase
  endfunction

  // Cyclic order ALU -> LOAD -> LINK -> ALU used by the round-robin search.
  function automatic wb_src_e next_src(input wb_src_e src);
    case (src)
      SRC_ALU:  return SRC_LOAD;
      SRC_LOAD: return SRC_LINK;
      default:  return SRC_ALU;
    endcase
  endfunction

endpackage

// File: rtl/wb_slot.sv
// One-entry holding buffer for a writeback producer; writes to r0 are accepted and dropped.
module wb_slot #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic [REG_W-1:0]  in_rd,
  input  logic              grant,
  output logic              in_ready,
  output logic              slot_valid,
  output logic [DATA_W-1:0] slot_data,
  output logic [REG_W-1:0]  slot_rd
);

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [REG_W-1:0]  rd_q, rd_d;
  logic              accept;

  // A granted entry leaves on this edge, so it can be refilled in the same cycle.
  assign in_ready = !valid_q || grant;
  assign accept   = in_valid && in_ready;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    rd_d    = rd_q;
    if (accept && (in_rd != '0)) begin
      valid_d = 1'b1;
      data_d  = in_data;
      rd_d    = in_rd;
    end else if (grant) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      rd_q    <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      rd_q    <= rd_d;
    end
  end

  assign slot_valid = valid_q;
  assign slot_data  = data_q;
  assign slot_rd    = rd_q;

endmodule

// File: rtl/wb_write_arbiter.sv
// Arbitrates ALU, load and link writebacks onto the single register-file write port.
// Build option: WB_ARB_RR_EN selects round-robin grant; default is fixed load > link > ALU.
module wb_write_arbiter
  import wb_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [DATA_W-1:0] alu_data,
  input  logic [REG_W-1:0]  alu_rd,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic [DATA_W-1:0] load_data,
  input  logic [REG_W-1:0]  load_rd,
  input  logic              link_valid,
  output logic              link_ready,
  input  logic [DATA_W-1:0] link_data,
  input  logic [REG_W-1:0]  link_rd,
  output logic [1:0]        wb_sel,
  output logic [DATA_W-1:0] wb_alu_data,
  output logic [DATA_W-1:0] wb_load_data,
  output logic [DATA_W-1:0] wb_link_data,
  output logic              rf_we,
  output logic [REG_W-1:0]  rf_waddr,
  output logic              wb_busy
);

  logic [2:0]        slot_v;
  logic [2:0]        grant_vec;
  logic [DATA_W-1:0] alu_sd, load_sd, link_sd;
  logic [REG_W-1:0]  alu_srd, load_srd, link_srd;
  wb_src_e           win_src;
  logic              win_any;

  wb_slot #(.DATA_W(DATA_W), .REG_W(REG_W)) u_alu_slot (
    .clk(clk), .reset_n(reset_n), .in_valid(alu_valid), .in_data(alu_data), .in_rd(alu_rd),
    .grant(grant_vec[SRC_ALU]), .in_ready(alu_ready), .slot_valid(slot_v[SRC_ALU]),
    .slot_data(alu_sd), .slot_rd(alu_srd)
  );

  wb_slot #(.DATA_W(DATA_W), .REG_W(REG_W)) u_load_slot (
    .clk(clk), .reset_n(reset_n), .in_valid(load_valid), .in_data(load_data), .in_rd(load_rd),
    .grant(grant_vec[SRC_LOAD]), .in_ready(load_ready), .slot_valid(slot_v[SRC_LOAD]),
    .slot_data(load_sd), .slot_rd(load_srd)
  );

  wb_slot #(.DATA_W(DATA_W), .REG_W(REG_W)) u_link_slot (
    .clk(clk), .reset_n(reset_n), .in_valid(link_valid), .in_data(link_data), .in_rd(link_rd),
    .grant(grant_vec[SRC_LINK]), .in_ready(link_ready), .slot_valid(slot_v[SRC_LINK]),
    .slot_data(link_sd), .slot_rd(link_srd)
  );

`ifdef WB_ARB_RR_EN
  wb_src_e ptr_q, ptr_d;
  wb_src_e cand0, cand1, cand2;

  // Search starts just after the last winner, so every source waits at most two writes.
  always_comb begin
    cand0   = next_src(ptr_q);
    cand1   = next_src(cand0);
    cand2   = next_src(cand1);
    win_any = |slot_v;
    win_src = cand2;
    if (slot_v[cand0])      win_src = cand0;
    else if (slot_v[cand1]) win_src = cand1;
    ptr_d = win_any ? win_src : ptr_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) ptr_q <= SRC_ALU;
    else          ptr_q <= ptr_d;
  end
`else
  always_comb begin
    win_any = |slot_v;
    win_src = SRC_ALU;
    if (slot_v[SRC_LOAD])      win_src = SRC_LOAD;
    else if (slot_v[SRC_LINK]) win_src = SRC_LINK;
  end
`endif

  always_comb begin
    grant_vec          = '0;
    grant_vec[win_src] = win_any;
  end

  logic              rf_we_q, rf_we_d;
  logic [REG_W-1:0]  waddr_q, waddr_d;
  logic [1:0]        sel_q, sel_d;
  logic [DATA_W-1:0] alu_q, alu_d, load_q, load_d, link_q, link_d;

  // Only the winner's mux input is reloaded; idle cycles hold select and address.
  always_comb begin
    rf_we_d = win_any;
    waddr_d = waddr_q;
    sel_d   = sel_q;
    alu_d   = alu_q;
    load_d  = load_q;
    link_d  = link_q;
    if (win_any) begin
      sel_d = src_to_sel(win_src);
      case (win_src)
        SRC_LOAD: begin waddr_d = load_srd; load_d = load_sd; end
        SRC_LINK: begin waddr_d = link_srd; link_d = link_sd; end
        default:  begin waddr_d = alu_srd;  alu_d  = alu_sd;  end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rf_we_q <= 1'b0;
      waddr_q <= '0;
      sel_q   <= WB_SEL_ALU;
      alu_q   <= '0;
      load_q  <= '0;
      link_q  <= '0;
    end else begin
      rf_we_q <= rf_we_d;
      waddr_q <= waddr_d;
      sel_q   <= sel_d;
      alu_q   <= alu_d;
      load_q  <= load_d;
      link_q  <= link_d;
    end
  end

  assign rf_we        = rf_we_q;
  assign rf_waddr     = waddr_q;
  assign wb_sel       = sel_q;
  assign wb_alu_data  = alu_q;
  assign wb_load_data = load_q;
  assign wb_link_data = link_q;
  assign wb_busy      = |slot_v;

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Directed self-checking bench for wb_write_arbiter (expectations follow WB_ARB_RR_EN).
module tb_wb_write_arbiter;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        alu_valid = 1'b0, load_valid = 1'b0, link_valid = 1'b0;
  logic        alu_ready, load_ready, link_ready;
  logic [31:0] alu_data = '0, load_data = '0, link_data = '0;
  logic [4:0]  alu_rd = '0, load_rd = '0, link_rd = '0;
  logic [1:0]  wb_sel;
  logic [31:0] wb_alu_data, wb_load_data, wb_link_data;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic        wb_busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wb_write_arbiter dut (
    .clk(clk), .reset_n(reset_n),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_data(alu_data), .alu_rd(alu_rd),
    .load_valid(load_valid), .load_ready(load_ready), .load_data(load_data), .load_rd(load_rd),
    .link_valid(link_valid), .link_ready(link_ready), .link_data(link_data), .link_rd(link_rd),
    .wb_sel(wb_sel), .wb_alu_data(wb_alu_data), .wb_load_data(wb_load_data),
    .wb_link_data(wb_link_data), .rf_we(rf_we), .rf_waddr(rf_waddr), .wb_busy(wb_busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    #12;
    checks++;
    if ({rf_we, wb_sel, rf_waddr, wb_busy} !== 9'b0) begin
      errors++;
      $display("[TB] FAIL reset_ctrl: got we=%b sel=%b waddr=%0d busy=%b, want all 0", rf_we, wb_sel, rf_waddr, wb_busy);
    end
    checks++;
    if ({wb_alu_data, wb_load_data, wb_link_data} !== 96'b0) begin
      errors++;
      $display("[TB] FAIL reset_data: got %h %h %h, want 0", wb_alu_data, wb_load_data, wb_link_data);
    end
    #10 reset_n = 1'b1;
    #1;
    checks++;
    if ({alu_ready, load_ready, link_ready} !== 3'b111) begin
      errors++;
      $display("[TB] FAIL reset_ready: got %b, want 111", {alu_ready, load_ready, link_ready});
    end
  endtask

  task automatic test_single_alu();
    tick();
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'h0000_1234;
    tick();
    alu_valid = 1'b0;
    checks++;
    if (rf_we !== 1'b0) begin
      errors++;
      $display("[TB] FAIL alu_latency: rf_we got %b want 0 in transfer cycle", rf_we);
    end
    tick();
    checks++;
    if ({rf_we, wb_sel, rf_waddr, wb_alu_data} !== {1'b1, 2'b00, 5'd5, 32'h0000_1234}) begin
      errors++;
      $display("[TB] FAIL alu_write: got we=%b sel=%b waddr=%0d data=%h, want 1/00/5/00001234", rf_we, wb_sel, rf_waddr, wb_alu_data);
    end
    tick();
    checks++;
    if ({rf_we, wb_sel, rf_waddr} !== {1'b0, 2'b00, 5'd5}) begin
      errors++;
      $display("[TB] FAIL alu_idle: got we=%b sel=%b waddr=%0d, want 0/00/5", rf_we, wb_sel, rf_waddr);
    end
  endtask

  task automatic test_simultaneous();
    logic [1:0] exp_sel [3];
    logic [4:0] exp_rd [3];
    logic       exp_alu_rdy [3];
    exp_sel = '{2'b01, 2'b10, 2'b00};
    exp_rd = '{5'd3, 5'd31, 5'd7};
    exp_alu_rdy = '{1'b0, 1'b1, 1'b1};
    alu_valid = 1'b1;  alu_rd = 5'd7;   alu_data = 32'hAAAA_0007;
    load_valid = 1'b1; load_rd = 5'd3;  load_data = 32'h1111_0003;
    link_valid = 1'b1; link_rd = 5'd31; link_data = 32'h0040_0100;
    tick();
    alu_valid = 1'b0; load_valid = 1'b0; link_valid = 1'b0;
    checks++;
    if (alu_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL sim_alu_wait: alu_ready got %b want 0", alu_ready);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({rf_we, wb_sel, rf_waddr} !== {1'b1, exp_sel[i], exp_rd[i]}) begin
        errors++;
        $display("[TB] FAIL sim_write%0d: got we=%b sel=%b waddr=%0d, want 1/%b/%0d", i, rf_we, wb_sel, rf_waddr, exp_sel[i], exp_rd[i]);
      end
      checks++;
      if (alu_ready !== exp_alu_rdy[i]) begin
        errors++;
        $display("[TB] FAIL sim_alu_ready%0d: got %b want %b", i, alu_ready, exp_alu_rdy[i]);
      end
    end
    checks++;
    if ({wb_alu_data, wb_load_data, wb_link_data} !== {32'hAAAA_0007, 32'h1111_0003, 32'h0040_0100}) begin
      errors++;
      $display("[TB] FAIL sim_data: got %h %h %h, want aaaa0007 11110003 00400100", wb_alu_data, wb_load_data, wb_link_data);
    end
    tick();
    checks++;
    if (rf_we !== 1'b0 || wb_busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL sim_drain: got we=%b busy=%b, want 0/0", rf_we, wb_busy);
    end
  endtask

  task automatic test_zero_dest();
    load_valid = 1'b1; load_rd = 5'd0; load_data = 32'hDEAD_BEEF;
    #1;
    checks++;
    if (load_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL zero_ready: load_ready got %b want 1", load_ready);
    end
    tick();
    load_valid = 1'b0;
    checks++;
    if (wb_busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL zero_stored: wb_busy got %b want 0", wb_busy);
    end
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (rf_we !== 1'b0 || wb_load_data !== 32'h1111_0003) begin
        errors++;
        $display("[TB] FAIL zero_write%0d: got we=%b data=%h, want 0/11110003", i, rf_we, wb_load_data);
      end
    end
  endtask

  task automatic test_contention();
    logic [1:0] exp_sel [4];
    logic [4:0] exp_rd [4];
`ifdef WB_ARB_RR_EN
    exp_sel = '{2'b01, 2'b00, 2'b01, 2'b00};
    exp_rd = '{5'd4, 5'd9, 5'd4, 5'd9};
`else
    exp_sel = '{2'b01, 2'b01, 2'b01, 2'b01};
    exp_rd = '{5'd4, 5'd4, 5'd4, 5'd4};
`endif
    alu_valid = 1'b1;  alu_rd = 5'd9;  alu_data = 32'h0000_0009;
    load_valid = 1'b1; load_rd = 5'd4; load_data = 32'h0000_0004;
    tick();
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if ({rf_we, wb_sel, rf_waddr} !== {1'b1, exp_sel[i], exp_rd[i]}) begin
        errors++;
        $display("[TB] FAIL contend%0d: got we=%b sel=%b waddr=%0d, want 1/%b/%0d", i, rf_we, wb_sel, rf_waddr, exp_sel[i], exp_rd[i]);
      end
`ifndef WB_ARB_RR_EN
      checks++;
      if (alu_ready !== 1'b0) begin
        errors++;
        $display("[TB] FAIL contend_alu_wait%0d: alu_ready got %b want 0", i, alu_ready);
      end
`endif
    end
    alu_valid = 1'b0; load_valid = 1'b0;
    repeat (4) tick();
    checks++;
    if (wb_busy !== 1'b0 || rf_we !== 1'b0) begin
      errors++;
      $display("[TB] FAIL contend_drain: got busy=%b we=%b, want 0/0", wb_busy, rf_we);
    end
  endtask

  task automatic test_reset_midrun();
    alu_valid = 1'b1;  alu_rd = 5'd12;  alu_data = 32'h0000_000C;
    load_valid = 1'b1; load_rd = 5'd13; load_data = 32'h0000_000D;
    link_valid = 1'b1; link_rd = 5'd14; link_data = 32'h0000_000E;
    tick();
    alu_valid = 1'b0; load_valid = 1'b0; link_valid = 1'b0;
    tick();
    checks++;
    if (rf_we !== 1'b1 || wb_busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL midrun_busy: got we=%b busy=%b, want 1/1", rf_we, wb_busy);
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({rf_we, wb_busy, wb_sel, rf_waddr} !== 9'b0 || wb_load_data !== 32'h0) begin
      errors++;
      $display("[TB] FAIL midrun_async: got we=%b busy=%b sel=%b waddr=%0d ld=%h, want all 0", rf_we, wb_busy, wb_sel, rf_waddr, wb_load_data);
    end
    #3 reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (rf_we !== 1'b0 || wb_busy !== 1'b0) begin
        errors++;
        $display("[TB] FAIL midrun_quiet%0d: got we=%b busy=%b, want 0/0", i, rf_we, wb_busy);
      end
    end
    checks++;
    if ({alu_ready, load_ready, link_ready} !== 3'b111) begin
      errors++;
      $display("[TB] FAIL midrun_ready: got %b want 111", {alu_ready, load_ready, link_ready});
    end
  endtask

  initial begin
    test_reset();
    test_single_alu();
    test_simultaneous();
    test_zero_dest();
    test_contention();
    test_reset_midrun();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_write_arbiter.md
# wb_write_arbiter

Shares the single register-file write port between the three writeback producers of the MIPS pipeline: ALU results, load-unit returns and jump-and-link return addresses. Each producer hands off over a valid/ready handshake into a one-entry holding slot. Each cycle the arbiter grants one occupied slot and registers its data, destination and the 2-bit writeback-select code. It sits between EX/MEM and the writeback 3:1 result mux, driving that mux's select and its three data inputs.

## Interface
- DATA_W, 32, datapath width
- REG_W, 5, register-address width
- clk  in  1  system clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- alu_valid / alu_ready  in / out  1  ALU handshake
- alu_data / alu_rd  in  DATA_W / REG_W  ALU result and destination
- load_valid / load_ready  in / out  1  load-unit handshake
- load_data / load_rd  in  DATA_W / REG_W  load data and destination
- link_valid / link_ready  in / out  1  link handshake
- link_data / link_rd  in  DATA_W / REG_W  return address and destination
- wb_sel  out  2  mux select: 00 ALU, 01 load, 10 link
- wb_alu_data, wb_load_data, wb_link_data  out  DATA_W  registered mux data inputs
- rf_we  out  1  register-file write enable
- rf_waddr  out  REG_W  register-file write address
- wb_busy  out  1  high while any slot is occupied

## Operation
- One slot per source, holding valid, data and rd.
- Transfer occurs on a rising edge with x_valid && x_ready.
- x_ready = !slot_valid || slot granted this cycle. A granted slot accepts a new transfer in the same cycle.
- A transfer with rd == 0 is consumed (ready high) but not stored, and never produces rf_we.
- Grant is combinational from slot valids. Default policy is fixed priority: load > link > ALU.
- Winner, registered on the next edge:
  - rf_we = 1, rf_waddr = rd, wb_sel = source code.
  - The winner's wb_*_data is loaded from its slot. The other wb_*_data hold their values.
  - The winning slot clears unless it is refilled in the same edge.
- No occupied slot: rf_we = 0, wb_sel and rf_waddr hold.
- The arbiter does not reorder same-rd writes. Upstream hazard logic guarantees at most one in-flight write per rd.

## Timing
- Reset (asynchronous, immediate):
  - slots invalid; rf_we = 0; wb_sel = 00; rf_waddr = 0; all wb_*_data = 0; wb_busy = 0; RR pointer = ALU.
  - readies read 1 after reset because all slots are empty.
- Latency: transfer at edge N, slot occupied in cycle N. If it wins in cycle N, rf_we is high for the whole cycle after edge N+1.
- Throughput: one register write per cycle.
- A losing source waits in its slot with ready low. Its held data is stable until granted.
- Three simultaneous transfers with fixed priority complete over three consecutive write cycles.
- Reset mid-operation discards all slots. No write is emitted after reset_n rises until a new transfer arrives.

## Configuration
- WB_ARB_RR_EN defined: round-robin grant.
  - Search order starts after the last-granted source, cyclic ALU → load → link → ALU.
  - The pointer updates only on a grant.
  - Any source waits at most two write cycles.
- WB_ARB_RR_EN undefined: fixed priority load > link > ALU, with no pointer register.

## Structure
- Shared package wb_pkg holds:
  - WB_SEL_ALU = 2'b00, WB_SEL_LOAD = 2'b01, WB_SEL_LINK = 2'b10.
  - The source-index typedef (ALU = 0, LOAD = 1, LINK = 2).
- Sub-module wb_slot, instantiated three times: a one-entry holding buffer with valid/ready, a grant input and rd == 0 drop.

## Test plan
- Reset: hold reset_n low → all outputs 0, wb_sel = 00. After release, all three readies read 1.
- Single ALU write: alu rd = 5, data 0x00001234 → one cycle after transfer, rf_we = 1, rf_waddr = 5, wb_sel = 00, wb_alu_data = 0x00001234.
- Simultaneous fixed priority: load rd = 3, link rd = 31, ALU rd = 7 in one edge → three write cycles in order sel 01/3, 10/31, 00/7. alu_ready is low until its grant.
- Zero destination: load rd = 0, data 0xDEADBEEF → load_ready = 1, no rf_we, wb_load_data unchanged.
- Round-robin (WB_ARB_RR_EN): ALU and load both valid every cycle → grants alternate 01, 00, 01, 00. Without the macro, load wins while ALU waits.
- Reset mid-run: assert reset_n while two slots are full → rf_we drops asynchronously and neither slot is ever written.
